// File: rtl/usb_rx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : usb_rx_sequencer                                                 |
// | Brief   : USB packet receive sequencer: SYNC, NRZI, de-stuff, bytes, EOP.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module usb_rx_sequencer #(
   parameter int SYNC_MIN_ZEROS = 5,
   parameter int STUFF_LEN      = 6,
   parameter int EOP_MAX_SE0    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       strobe,
   input  logic [1:0] line_state,
   output logic       rx_active,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_error
);

   // d_port_t encoding {D+, D-}
   localparam logic [1:0] c_se0 = 2'b00;
   localparam logic [1:0] c_k   = 2'b01;
   localparam logic [1:0] c_j   = 2'b10;

   localparam logic [3:0] c_sync_min  = 4'(SYNC_MIN_ZEROS);
   localparam logic [3:0] c_stuff_len = 4'(STUFF_LEN);
   localparam logic [3:0] c_eop_max   = 4'(EOP_MAX_SE0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_DATA  = 3'd2,
      S_EOP   = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   state_t     r_state;
   logic [1:0] r_prev;
   logic [3:0] r_zeros;
   logic [3:0] r_ones;
   logic [3:0] r_bitcnt;
   logic [3:0] r_se0cnt;
   logic [7:0] r_shreg;
   logic       r_frame_err;
   logic       r_rx_active;
   logic       r_rx_valid;
   logic [7:0] r_rx_data;
   logic       r_rx_error;

   logic       w_is_jk;
   logic       w_bit;
   logic [7:0] w_shift;

   assign w_is_jk = (line_state == c_j) || (line_state == c_k);
   assign w_bit   = (line_state == r_prev);
   assign w_shift = {w_bit, r_shreg[7:1]};

   assign rx_active = r_rx_active;
   assign rx_valid  = r_rx_valid;
   assign rx_data   = r_rx_data;
   assign rx_error  = r_rx_error;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_prev      <= c_j;
         r_zeros     <= 4'd0;
         r_ones      <= 4'd0;
         r_bitcnt    <= 4'd0;
         r_se0cnt    <= 4'd0;
         r_shreg     <= 8'h00;
         r_frame_err <= 1'b0;
         r_rx_active <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_rx_data   <= 8'h00;
         r_rx_error  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_error <= 1'b0;
         if (strobe) begin
            if (w_is_jk) begin
               r_prev <= line_state;
            end
            case (r_state)
               S_IDLE: begin
                  if (line_state == c_k) begin
                     r_state <= S_SYNC;
                     r_zeros <= 4'd1;
                  end
               end

               // SYNC failures are silent: the line may simply be noise
               S_SYNC: begin
                  if (!w_is_jk) begin
                     r_state <= S_IDLE;
                  end else if (!w_bit) begin
                     if (r_zeros != 4'hF) begin
                        r_zeros <= r_zeros + 4'd1;
                     end
                  end else if (r_zeros >= c_sync_min) begin
                     r_state     <= S_DATA;
                     r_rx_active <= 1'b1;
                     r_ones      <= 4'd1;
                     r_bitcnt    <= 4'd0;
                     r_frame_err <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end

               S_DATA: begin
                  if (w_is_jk) begin
                     if (r_ones == c_stuff_len) begin
                        if (w_bit) begin
                           r_state     <= S_ABORT;
                           r_rx_active <= 1'b0;
                           r_rx_error  <= 1'b1;
                        end else begin
                           r_ones <= 4'd0;
                        end
                     end else begin
                        r_shreg <= w_shift;
                        r_ones  <= w_bit ? r_ones + 4'd1 : 4'd0;
                        if (r_bitcnt == 4'd7) begin
                           r_rx_data  <= w_shift;
                           r_rx_valid <= 1'b1;
                           r_bitcnt   <= 4'd0;
                        end else begin
                           r_bitcnt <= r_bitcnt + 4'd1;
                        end
                     end
                  end else if (line_state == c_se0) begin
                     r_state     <= S_EOP;
                     r_se0cnt    <= 4'd1;
                     r_frame_err <= (r_bitcnt != 4'd0);
                  end else begin
                     r_state     <= S_ABORT;
                     r_rx_active <= 1'b0;
                     r_rx_error  <= 1'b1;
                  end
               end

               // A truncated final byte is only reported once the EOP completes
               S_EOP: begin
                  if (line_state == c_se0) begin
                     if (r_se0cnt >= c_eop_max) begin
                        r_state     <= S_ABORT;
                        r_rx_active <= 1'b0;
                        r_rx_error  <= 1'b1;
                     end else begin
                        r_se0cnt <= r_se0cnt + 4'd1;
                     end
                  end else if (line_state == c_j) begin
                     r_state     <= S_IDLE;
                     r_rx_active <= 1'b0;
                     r_rx_error  <= r_frame_err;
                  end else begin
                     r_state     <= S_ABORT;
                     r_rx_active <= 1'b0;
                     r_rx_error  <= 1'b1;
                  end
               end

               S_ABORT: begin
                  if (line_state == c_j) begin
                     r_state <= S_IDLE;
                  end
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
